fft_st_framer: RTL and testbench
================================

FFT_ST_FRAMER -- requirements
Module: fft_st_framer

Interface
REQ-001 SHALL have parameter DW, default 16: sample/data width, both directions.
REQ-002 SHALL have parameter N, default 4096: samples per packet; legal range 2..65536.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: in_data in DW, in_valid in 1, in_ready out 1: raw sample input handshake.
REQ-006 SHALL have ports: src_data out DW, src_valid out 1, src_ready in 1, src_sop out 1, src_eop out 1, src_error out 2: Avalon-ST source toward FFT sink.
REQ-007 SHALL have ports: snk_data in DW, snk_valid in 1, snk_ready out 1, snk_sop in 1, snk_eop in 1, snk_error in 2: Avalon-ST sink from FFT source.
REQ-008 SHALL have ports: out_data out DW, out_valid out 1: last accepted result word, one-cycle valid pulse.
REQ-009 SHALL have ports: frame_cnt out 16 (completed result packets, wraps), err_flag out 1 (sticky), clr_err in 1 (clears err_flag).

Function
REQ-010 Source FSM SHALL have states IDLE and STREAM; sample counter scnt width ceil(log2 N).
REQ-011 in_ready SHALL equal (!src_valid || src_ready); a sample is taken when in_valid && in_ready.
REQ-012 On take, src_data/src_valid SHALL load next cycle (latency 1); src_sop=1 iff scnt==0, src_eop=1 iff scnt==N-1.
REQ-013 src_* SHALL hold stable while src_valid && !src_ready; src_valid drops only after a transfer with no new take.
REQ-014 scnt SHALL increment per take, wrap N-1->0; FSM IDLE->STREAM on first take, STREAM->IDLE on take with scnt==N-1.
REQ-015 Simultaneous transfer and take SHALL replace register contents with no bubble (full throughput).
REQ-016 src_error SHALL be constant 2'b00.
REQ-017 snk_ready SHALL be 1 whenever reset is deasserted (block never back-pressures the FFT).
REQ-018 On snk_valid, out_data SHALL register snk_data and out_valid pulse one cycle later.
REQ-019 Sink counter rcnt SHALL increment per snk_valid beat, reset to 1 on beat with snk_sop, to 0 after snk_eop beat.
REQ-020 frame_cnt SHALL increment on each snk_valid && snk_eop beat, wrapping 0xFFFF->0.
REQ-021 clr_err and a new error on the same cycle: set SHALL win.

Reset
REQ-022 During reset: in_ready=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, out_valid=0, out_data=0, frame_cnt=0, err_flag=0, snk_ready=0, FSM=IDLE, scnt=rcnt=0.
REQ-023 Reset mid-packet SHALL abandon the packet; the first take after release SHALL carry src_sop=1.
REQ-024 Reset SHALL assert asynchronously and deassert synchronously to clk as seen by all registers.

Configuration
REQ-025 Macro FFT_ST_FRAMER_ERRCHK_EN defined: err_flag SHALL set on snk_error!=0, on snk_sop while rcnt inside packet, on snk_eop with rcnt!=N-1 before beat, or on non-sop beat while idle.
REQ-026 Macro undefined: err_flag SHALL be constant 0, clr_err ignored, rcnt logic removed; all other behaviour identical.

Structure
REQ-027 Shared package fft_st_pkg SHALL hold src FSM state typedef, error-code widths (2) and frame_cnt width (16).
REQ-028 Framing checker SHALL be one sub-module fft_st_chk, instantiated only under FFT_ST_FRAMER_ERRCHK_EN.

Verification
REQ-029 N=8, src_ready=1, 8 continuous samples 1..8 -> src_data 1..8 on cycles 1..8, sop on 1, eop on 8, in_ready always 1.
REQ-030 N=8, src_ready low for 3 cycles on beat 4 -> src_data=4 held 3 cycles, in_ready=0 there, no sample lost or duplicated.
REQ-031 Two back-to-back packets of 8 -> sop on beats 1 and 9, eop on 8 and 16, FSM returns IDLE after beat 16.
REQ-032 Sink packet of 8 with sop/eop correct -> frame_cnt 0->1, out_data mirrors snk_data one cycle later, err_flag=0.
REQ-033 ERRCHK_EN, eop on sink beat 5 of N=8 -> err_flag=1 next cycle, stays 1 until clr_err, then 0.
REQ-034 Reset pulse after sample 3 of 8 -> all outputs at reset values; next take emits sop=1 with its data.

Source files
------------

// File: rtl/fft_st_pkg.sv
// Shared types and widths for the FFT Avalon-ST framer and its framing checker.
// No logic, so no latency.
// No flow control here; the modules that import it carry the handshakes.
package fft_st_pkg;

  // Source-side packet state: waiting for a first sample, or inside a packet.
  typedef enum logic [0:0] {
    SRC_IDLE   = 1'b0,
    SRC_STREAM = 1'b1
  } src_state_t;

  localparam int ERR_W  = 2;   // Avalon-ST error field width
  localparam int FCNT_W = 16;  // completed-packet counter width

  // Width of a counter that covers sample indices 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_st_chk.sv
// Checks the framing of packets coming back from the FFT source and raises a sticky error flag.
// The flag rises one cycle after the offending beat.
// Never stalls; it only watches accepted beats.
module fft_st_chk
  import fft_st_pkg::*;
#(
  parameter int N = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_i,
  input  logic             sop_i,
  input  logic             eop_i,
  input  logic [ERR_W-1:0] error_i,
  input  logic             clr_err_i,
  output logic             err_flag_o
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // rcnt holds the number of beats seen in the current packet; 0 means no packet is open.
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          err_q, err_set;

  // Classify the current beat and compute the next beat count.
  always_comb begin
    rcnt_d  = rcnt_q;
    err_set = 1'b0;
    if (beat_i) begin
      if (error_i != '0)              err_set = 1'b1;
      if (sop_i && rcnt_q != '0)      err_set = 1'b1;  // new packet starts before the old one ended
      if (eop_i && rcnt_q != LAST)    err_set = 1'b1;  // packet ends at the wrong length
      if (!sop_i && rcnt_q == '0)     err_set = 1'b1;  // data beat with no open packet
      if (eop_i)                      rcnt_d = '0;
      else if (sop_i)                 rcnt_d = CW'(1);
      else                            rcnt_d = rcnt_q + CW'(1);
    end
  end

  // Update the beat counter and the sticky flag; a new error wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      if (err_set)        err_q <= 1'b1;
      else if (clr_err_i) err_q <= 1'b0;
    end
  end

  assign err_flag_o = err_q;

endmodule

// File: rtl/fft_st_framer.sv
// Frames raw samples into N-sample Avalon-ST packets for an FFT and captures the returned result stream.
// Source latency is 1 cycle at full throughput; a result word appears 1 cycle after its sink beat.
// in_ready follows src_ready through a one-deep register; the sink side never back-pressures. Framing check: FFT_ST_FRAMER_ERRCHK_EN.
module fft_st_framer
  import fft_st_pkg::*;
#(
  parameter int DW = 16,
  parameter int N  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [ERR_W-1:0]  src_error,
  input  logic [DW-1:0]     snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [ERR_W-1:0]  snk_error,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_flag,
  input  logic              clr_err
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reset: asserted asynchronously, released on a clock edge so every register leaves reset together.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Two-stage reset release synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Source side: one output register that refills on the same cycle it drains.
  src_state_t    state_q;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [DW-1:0] src_data_q;
  logic          src_valid_q, src_sop_q, src_eop_q;
  logic          take;

  assign in_ready = rst_n && (!src_valid_q || src_ready);
  assign take     = in_valid && in_ready;
  assign scnt_d   = (scnt_q == LAST) ? '0 : scnt_q + CW'(1);

  // Packet FSM with registered Avalon-ST outputs and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SRC_IDLE;
      scnt_q      <= '0;
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
    end else if (take) begin
      src_data_q  <= in_data;
      src_valid_q <= 1'b1;
      src_sop_q   <= (scnt_q == '0);
      src_eop_q   <= (scnt_q == LAST);
      scnt_q      <= scnt_d;
      case (state_q)
        SRC_IDLE:   state_q <= SRC_STREAM;
        SRC_STREAM: if (scnt_q == LAST) state_q <= SRC_IDLE;
        default:    state_q <= SRC_IDLE;
      endcase
    end else if (src_ready) begin
      // Word left with nothing behind it: go empty.
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
    end
  end

  assign src_data  = src_data_q;
  assign src_valid = src_valid_q;
  assign src_sop   = src_sop_q;
  assign src_eop   = src_eop_q;
  assign src_error = '0;

  // Sink side: always ready once out of reset.
  logic              snk_beat;
  logic [DW-1:0]     out_data_q;
  logic              out_valid_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  assign snk_ready = rst_n;
  assign snk_beat  = snk_valid && snk_ready;

  // Capture each result word and count completed result packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      out_valid_q <= snk_beat;
      if (snk_beat)            out_data_q  <= snk_data;
      if (snk_beat && snk_eop) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

`ifdef FFT_ST_FRAMER_ERRCHK_EN
  fft_st_chk #(.N(N)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_i     (snk_beat),
    .sop_i      (snk_sop),
    .eop_i      (snk_eop),
    .error_i    (snk_error),
    .clr_err_i  (clr_err),
    .err_flag_o (err_flag)
  );
`else
  // Without the checker the framing inputs and the clear have no effect.
  logic unused_chk_in;
  assign unused_chk_in = ^{clr_err, snk_sop, snk_error};
  assign err_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_st_framer.sv
// Directed bench for fft_st_framer with N=8: source framing, stall, back-to-back packets,
// result capture, framing error flag and mid-packet reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_fft_st_framer;
  import fft_st_pkg::*;

  localparam int DW = 16;
  localparam int N  = 8;
`ifdef FFT_ST_FRAMER_ERRCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic [ERR_W-1:0]  src_error;
  logic [DW-1:0]     snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic              snk_sop;
  logic              snk_eop;
  logic [ERR_W-1:0]  snk_error;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_flag;
  logic              clr_err;

  fft_st_framer #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_error (src_error),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .snk_sop   (snk_sop),
    .snk_eop   (snk_eop),
    .snk_error (snk_error),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_cnt (frame_cnt),
    .err_flag  (err_flag),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the source input is ready again after reset.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_after_reset", in_ready, 1'b1);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          sr;
    logic          e_ir;
    logic          e_sv;
    logic [DW-1:0] e_sd;
    logic          e_sop;
    logic          e_eop;
  } vec_t;

  vec_t          tbl [12];
  logic [DW-1:0] got [$];

  initial begin
    // One packet of 1..8, with src_ready low for 3 cycles while beat 4 is presented.
    //            in_valid in_data src_ready | in_ready src_valid src_data sop eop (after edge)
    tbl[0]  = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'd2, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'd3, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'd6, 1'b1, 1'b1, 1'b1, 16'd6, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'd7, 1'b1, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'd8, 1'b1, 1'b1, 1'b1, 16'd8, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};

    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    src_ready = 1'b1;
    snk_data  = '0;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_error = '0;
    clr_err   = 1'b0;

    // Reset state.
    step(); step(); step();
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_src_valid", src_valid, 1'b0);
    chk("rst_src_sop",   src_sop,   1'b0);
    chk("rst_src_eop",   src_eop,   1'b0);
    chk("rst_src_data",  src_data,  16'd0);
    chk("rst_snk_ready", snk_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  16'd0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_err_flag",  err_flag,  1'b0);
    chk("rst_state",     dut.state_q, SRC_IDLE);
    reset = 1'b1;
    wait_ready();

    // Table: single packet with a stall.
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      src_ready = tbl[i].sr;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
      if (src_valid && src_ready) got.push_back(src_data);
      step();
      chk($sformatf("v%0d_src_valid", i), src_valid, tbl[i].e_sv);
      if (tbl[i].e_sv) begin
        chk($sformatf("v%0d_src_data", i), src_data, tbl[i].e_sd);
        chk($sformatf("v%0d_src_sop", i),  src_sop,  tbl[i].e_sop);
        chk($sformatf("v%0d_src_eop", i),  src_eop,  tbl[i].e_eop);
      end
      chk($sformatf("v%0d_src_error", i), src_error, 2'b00);
    end
    chk("stall_xfer_count", got.size(), 8);
    for (int k = 0; k < got.size() && k < 8; k++)
      chk($sformatf("stall_xfer%0d", k), got[k], k + 1);
    chk("stall_state_idle", dut.state_q, SRC_IDLE);

    // Two back-to-back packets of 8 at full throughput.
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_data   = 16'(i + 1);
      src_ready = 1'b1;
      #1;
      chk($sformatf("b2b%0d_in_ready", i), in_ready, 1'b1);
      step();
      chk($sformatf("b2b%0d_data", i), src_data, i + 1);
      chk($sformatf("b2b%0d_sop", i),  src_sop,  (i % 8) == 0);
      chk($sformatf("b2b%0d_eop", i),  src_eop,  (i % 8) == 7);
      chk($sformatf("b2b%0d_state", i), dut.state_q,
          ((i % 8) == 7) ? SRC_IDLE : SRC_STREAM);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drained", src_valid, 1'b0);

    // Well-formed result packet of 8.
    for (int i = 0; i < 8; i++) begin
      snk_valid = 1'b1;
      snk_data  = 16'h100 + 16'(i);
      snk_sop   = (i == 0);
      snk_eop   = (i == 7);
      #1;
      chk($sformatf("snk%0d_ready", i), snk_ready, 1'b1);
      step();
      chk($sformatf("snk%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("snk%0d_out_data", i),  out_data,  16'h100 + i);
    end
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    step();
    chk("snk_out_valid_pulse", out_valid, 1'b0);
    chk("snk_frame_cnt",       frame_cnt, 16'd1);
    chk("snk_err_clean",       err_flag,  1'b0);

    // Result packet that ends early: eop on beat 5.
    for (int i = 0; i < 5; i++) begin
      snk_valid = 1'b1;
      snk_data  = 16'h200 + 16'(i);
      snk_sop   = (i == 0);
      snk_eop   = (i == 4);
      step();
      chk($sformatf("short%0d_err", i), err_flag, (i == 4) ? EXP_ERR : 1'b0);
    end
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("short_hold%0d_err", i), err_flag, EXP_ERR);
    end
    chk("short_frame_cnt", frame_cnt, 16'd2);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err_cleared", err_flag, 1'b0);
    // Stray data beat with no open packet, on the same cycle as a clear.
    snk_valid = 1'b1;
    snk_data  = 16'h0abc;
    clr_err   = 1'b1;
    step();
    snk_valid = 1'b0;
    clr_err   = 1'b0;
    chk("set_wins_err", err_flag, EXP_ERR);
    chk("stray_out_data", out_data, 16'h0abc);

    // Reset in the middle of a source packet.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h30 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_src_valid", src_valid, 1'b0);
    chk("mid_rst_in_ready",  in_ready,  1'b0);
    chk("mid_rst_src_sop",   src_sop,   1'b0);
    chk("mid_rst_src_data",  src_data,  16'd0);
    chk("mid_rst_out_data",  out_data,  16'd0);
    chk("mid_rst_frame_cnt", frame_cnt, 16'd0);
    chk("mid_rst_err_flag",  err_flag,  1'b0);
    chk("mid_rst_snk_ready", snk_ready, 1'b0);
    step(); step();
    reset = 1'b1;
    wait_ready();
    in_valid = 1'b1;
    in_data  = 16'h0055;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", src_valid, 1'b1);
    chk("post_rst_sop",   src_sop,   1'b1);
    chk("post_rst_eop",   src_eop,   1'b0);
    chk("post_rst_data",  src_data,  16'h0055);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
